// File: rtl/ctrl_pkg.sv
// Shared definitions for the 8-bit CPU fetch/decode/sequence controller:
// opcodes, FSM states, strobe-vector bit positions and the decoder payload.
package ctrl_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned TGT_W       = 4;
  localparam int unsigned NUM_STROBES = 18;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_ADC = 5'h03;
  localparam logic [4:0] OP_SBB = 5'h04;
  localparam logic [4:0] OP_MUL = 5'h05;
  localparam logic [4:0] OP_DIV = 5'h06;
  localparam logic [4:0] OP_INC = 5'h07;
  localparam logic [4:0] OP_DEC = 5'h08;
  localparam logic [4:0] OP_SHL = 5'h09;
  localparam logic [4:0] OP_SHR = 5'h0A;
  localparam logic [4:0] OP_NOT = 5'h0B;
  localparam logic [4:0] OP_NEG = 5'h0C;
  localparam logic [4:0] OP_AND = 5'h0D;
  localparam logic [4:0] OP_OR  = 5'h0E;
  localparam logic [4:0] OP_JMP = 5'h0F;
  localparam logic [4:0] OP_JA  = 5'h10;
  localparam logic [4:0] OP_JB  = 5'h11;
  localparam logic [4:0] OP_JE  = 5'h12;
  localparam logic [4:0] OP_HLT = 5'h1F;

  // Strobe bit n corresponds to opcode n+1, so decode can shift instead of table-lookup.
  localparam int unsigned SB_ADD = 0;
  localparam int unsigned SB_SUB = 1;
  localparam int unsigned SB_ADC = 2;
  localparam int unsigned SB_SBB = 3;
  localparam int unsigned SB_MUL = 4;
  localparam int unsigned SB_DIV = 5;
  localparam int unsigned SB_INC = 6;
  localparam int unsigned SB_DEC = 7;
  localparam int unsigned SB_SHL = 8;
  localparam int unsigned SB_SHR = 9;
  localparam int unsigned SB_NOT = 10;
  localparam int unsigned SB_NEG = 11;
  localparam int unsigned SB_AND = 12;
  localparam int unsigned SB_OR  = 13;
  localparam int unsigned SB_JMP = 14;
  localparam int unsigned SB_JA  = 15;
  localparam int unsigned SB_JB  = 16;
  localparam int unsigned SB_JE  = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [NUM_STROBES-1:0] strobes;
    logic                   is_alu;
    logic                   is_jump;
    logic                   hi_wb;
    logic                   is_hlt;
    logic                   is_illegal;
  } dec_t;

  function automatic logic [TGT_W-1:0] onehot2to4(input logic [1:0] sel);
    return TGT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/ctrl_seq_op_decode.sv
// Combinational opcode decoder: opcode byte -> strobe vector and instruction class.
module op_decode
  import ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] i_opcode,
  output dec_t              o_dec_c
);

  always_comb begin
    o_dec_c = '0;
    case (i_opcode[4:0])
      OP_NOP: begin
      end
      OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_MUL, OP_DIV, OP_INC,
      OP_DEC, OP_SHL, OP_SHR, OP_NOT, OP_NEG, OP_AND, OP_OR:
        o_dec_c.is_alu = 1'b1;
      OP_JMP, OP_JA, OP_JB, OP_JE:
        o_dec_c.is_jump = 1'b1;
      OP_HLT:
        o_dec_c.is_hlt = 1'b1;
      default:
        o_dec_c.is_illegal = 1'b1;
    endcase

    o_dec_c.hi_wb = (i_opcode[4:0] == OP_MUL) || (i_opcode[4:0] == OP_DIV);

    if (o_dec_c.is_alu || o_dec_c.is_jump) begin
      o_dec_c.strobes = NUM_STROBES'(1) << (i_opcode[4:0] - 5'd1);
    end

    // Any set bit in [7:5] makes the whole opcode undefined.
    if (i_opcode[7:5] != 3'b000) begin
      o_dec_c            = '0;
      o_dec_c.is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/sequence controller in front of the ALU: two-byte fetch, one-hot
// ALU strobes, register selects, write-back pulses and the program counter.
module ctrl_seq
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [TGT_W-1:0]  Tgt1,
  output logic [TGT_W-1:0]  Tgt2,
  output logic              IADD,
  output logic              ISUB,
  output logic              IADC,
  output logic              ISBB,
  output logic              IMUL,
  output logic              IDIV,
  output logic              IINC,
  output logic              IDEC,
  output logic              ISHL,
  output logic              ISHR,
  output logic              INOT,
  output logic              INEG,
  output logic              IAND,
  output logic              IOR,
  output logic              IJMP,
  output logic              IJA,
  output logic              IJB,
  output logic              IJE,
  output logic              EALU,
  input  logic              IJ,
  output logic              wb_en,
  output logic              wb_hi_en,
  output logic              flags_we,
  output logic [DATA_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  state_t                 r_state,    w_state_nxt;
  logic [DATA_W-1:0]      r_pc,       w_pc_nxt;
  logic [DATA_W-1:0]      r_opcode,   w_opcode_nxt;
  logic [DATA_W-1:0]      r_operand,  w_operand_nxt;
  logic [TGT_W-1:0]       r_tgt1,     w_tgt1_nxt;
  logic [TGT_W-1:0]       r_tgt2,     w_tgt2_nxt;
  logic [NUM_STROBES-1:0] r_strobes,  w_strobes_nxt;
  logic                   r_ealu,     w_ealu_nxt;
  logic                   r_wb_en,    w_wb_en_nxt;
  logic                   r_wb_hi_en, w_wb_hi_en_nxt;
  logic                   r_flags_we, w_flags_we_nxt;
  logic                   r_ij,       w_ij_nxt;
  logic                   r_mem_rd,   w_mem_rd_nxt;
  logic                   r_halted,   w_halted_nxt;
  logic                   r_illegal,  w_illegal_nxt;
  dec_t                   w_dec;

  // Decode always looks at the latched opcode; it is stable from FETCH1 through WB.
  op_decode u_op_decode (
    .i_opcode (r_opcode),
    .o_dec_c  (w_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_opcode   <= '0;
      r_operand  <= '0;
      r_tgt1     <= '0;
      r_tgt2     <= '0;
      r_strobes  <= '0;
      r_ealu     <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_hi_en <= 1'b0;
      r_flags_we <= 1'b0;
      r_ij       <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_opcode   <= w_opcode_nxt;
      r_operand  <= w_operand_nxt;
      r_tgt1     <= w_tgt1_nxt;
      r_tgt2     <= w_tgt2_nxt;
      r_strobes  <= w_strobes_nxt;
      r_ealu     <= w_ealu_nxt;
      r_wb_en    <= w_wb_en_nxt;
      r_wb_hi_en <= w_wb_hi_en_nxt;
      r_flags_we <= w_flags_we_nxt;
      r_ij       <= w_ij_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_halted   <= w_halted_nxt;
      r_illegal  <= w_illegal_nxt;
    end
  end

  // Pulse outputs are computed for the state being entered so they are
  // registered yet aligned with that state's cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_opcode_nxt   = r_opcode;
    w_operand_nxt  = r_operand;
    w_tgt1_nxt     = r_tgt1;
    w_tgt2_nxt     = r_tgt2;
    w_ij_nxt       = r_ij;
    w_illegal_nxt  = r_illegal;
    w_strobes_nxt  = '0;
    w_ealu_nxt     = 1'b0;
    w_wb_en_nxt    = 1'b0;
    w_wb_hi_en_nxt = 1'b0;
    w_flags_we_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH0;
      end
      ST_FETCH0: begin
        if (mem_ack) begin
          w_opcode_nxt = mem_data;
          w_pc_nxt     = r_pc + 8'd1;
          w_state_nxt  = ST_FETCH1;
        end
      end
      ST_FETCH1: begin
        if (mem_ack) begin
          w_operand_nxt = mem_data;
          w_pc_nxt      = r_pc + 8'd1;
          if (w_dec.is_alu) begin
            w_tgt1_nxt = onehot2to4(mem_data[7:6]);
            w_tgt2_nxt = onehot2to4(mem_data[5:4]);
          end else begin
            w_tgt1_nxt = '0;
            w_tgt2_nxt = '0;
          end
          if (w_dec.is_hlt || w_dec.is_illegal) begin
            w_state_nxt   = ST_HALT;
            w_illegal_nxt = w_dec.is_illegal;
          end else begin
            w_state_nxt   = ST_EXEC;
            w_strobes_nxt = w_dec.strobes;
            w_ealu_nxt    = |w_dec.strobes;
          end
        end
      end
      ST_EXEC: begin
        w_ij_nxt       = IJ;
        w_wb_en_nxt    = w_dec.is_alu;
        w_flags_we_nxt = w_dec.is_alu;
        w_wb_hi_en_nxt = w_dec.is_alu && w_dec.hi_wb;
        w_state_nxt    = ST_WB;
      end
      ST_WB: begin
        if (w_dec.is_jump && ((r_opcode[4:0] == OP_JMP) || r_ij)) begin
          w_pc_nxt = r_operand;
        end
        w_state_nxt = ST_FETCH0;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_mem_rd_nxt = (w_state_nxt == ST_FETCH0) || (w_state_nxt == ST_FETCH1);
    w_halted_nxt = (w_state_nxt == ST_HALT);
  end

  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign mem_rd   = r_mem_rd;
  assign Tgt1     = r_tgt1;
  assign Tgt2     = r_tgt2;
  assign EALU     = r_ealu;
  assign wb_en    = r_wb_en;
  assign wb_hi_en = r_wb_hi_en;
  assign flags_we = r_flags_we;
  assign halted   = r_halted;
  assign illegal  = r_illegal;

  assign IADD = r_strobes[SB_ADD];
  assign ISUB = r_strobes[SB_SUB];
  assign IADC = r_strobes[SB_ADC];
  assign ISBB = r_strobes[SB_SBB];
  assign IMUL = r_strobes[SB_MUL];
  assign IDIV = r_strobes[SB_DIV];
  assign IINC = r_strobes[SB_INC];
  assign IDEC = r_strobes[SB_DEC];
  assign ISHL = r_strobes[SB_SHL];
  assign ISHR = r_strobes[SB_SHR];
  assign INOT = r_strobes[SB_NOT];
  assign INEG = r_strobes[SB_NEG];
  assign IAND = r_strobes[SB_AND];
  assign IOR  = r_strobes[SB_OR];
  assign IJMP = r_strobes[SB_JMP];
  assign IJA  = r_strobes[SB_JA];
  assign IJB  = r_strobes[SB_JB];
  assign IJE  = r_strobes[SB_JE];

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Fetch/decode/sequence controller sitting directly upstream of the ALU in the 8-bit CPU model. It fetches two-byte instructions over a simple read handshake and drives the ALU's one-hot operation strobes, EALU and Tgt1/Tgt2 register selects. It samples the ALU's IJ jump result and issues single-cycle register-file/flags write-back enables. It also maintains the 8-bit program counter.

## Interface
- No parameters; data/address width fixed at 8.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  8  fetch address (= pc).
- mem_rd  out  1  fetch request.
- mem_ack  in  1  memory ready; transfer occurs on a cycle with mem_rd && mem_ack.
- mem_data  in  8  fetched byte, valid when mem_ack=1.
- Tgt1, Tgt2  out  4 each  one-hot destination/source register select (0001=R0 … 1000=R3).
- IADD, ISUB, IADC, ISBB, IMUL, IDIV, IINC, IDEC, ISHL, ISHR, INOT, INEG, IAND, IOR, IJMP, IJA, IJB, IJE  out  1 each  ALU operation strobes, at most one high.
- EALU  out  1  ALU enable.
- IJ  in  1  ALU jump-taken result.
- wb_en  out  1  write ALU Dout to register selected by Tgt1.
- wb_hi_en  out  1  write Dout_R1 (MUL/DIV high byte/remainder).
- flags_we  out  1  latch ALU Flags_out.
- pc  out  8  program counter.
- halted  out  1  sequencer stopped.
- illegal  out  1  stopped on an undefined opcode.

## Operation
- Instruction layout:
  - Byte 0 is the opcode; only bits [4:0] are decoded, and bits [7:5] must be 0, otherwise the opcode is illegal.
  - Byte 1 for ALU ops: [7:6]=rd and [5:4]=rs; [3:0] are ignored.
  - Byte 1 for jumps: the absolute target address.
- Opcodes: 00 NOP, 01 ADD, 02 SUB, 03 ADC, 04 SBB, 05 MUL, 06 DIV, 07 INC, 08 DEC, 09 SHL, 0A SHR, 0B NOT, 0C NEG, 0D AND, 0E OR, 0F JMP, 10 JA, 11 JB, 12 JE, 1F HLT. Every other code is illegal.
- States and transitions:
  - IDLE goes to FETCH0 on the first clock after reset.
  - FETCH0 latches the opcode on transfer, sets pc+1, and goes to FETCH1.
  - FETCH1 latches the operand on transfer and sets pc+1.
    - For ALU ops it loads Tgt1=onehot(rd) and Tgt2=onehot(rs); for all other opcodes it loads Tgt1=Tgt2=0.
    - HLT goes to HALT. An illegal opcode goes to HALT with illegal=1. Everything else goes to EXEC.
  - EXEC asserts the matching strobe plus EALU for one cycle (NOP asserts neither) and samples IJ. It goes to WB.
  - WB handles write-back and pc, then goes to FETCH0.
    - ALU ops (ADD..OR): wb_en=1 and flags_we=1; MUL and DIV also assert wb_hi_en=1.
    - Jumps: pc←target if JMP, or if JA/JB/JE with the sampled IJ=1. Otherwise pc keeps its sequential value.
  - HALT is terminal: mem_rd=0 and halted=1 until reset.
- mem_rd=1 only in FETCH0/FETCH1. While mem_ack=0, mem_rd and mem_addr stay stable and the state holds.
- pc arithmetic is modulo 256: 0xFF+1 wraps to 0x00, including when wrapping between the opcode and operand fetch.
- Tgt1/Tgt2 hold from FETCH1 completion until the next FETCH1 completion.

## Timing
- Reset values: pc=0, mem_addr=0, mem_rd=0, Tgt1=Tgt2=0, all strobes=0, EALU=0, wb_en=wb_hi_en=flags_we=0, halted=0, illegal=0. State is IDLE.
- Reset asserted mid-instruction clears all of the above immediately (asynchronously). Any in-flight fetch is abandoned.
- Zero-wait memory gives 4 cycles per instruction: FETCH0, FETCH1, EXEC, WB. Each mem_ack wait cycle adds one cycle.
- Strobes, EALU, wb_en, wb_hi_en and flags_we are registered outputs. Each is a single-cycle pulse.
- IJ is sampled only at the EXEC-cycle clock edge; IJ in any other cycle is ignored.
- A taken jump's pc is visible on mem_addr in the first FETCH0 cycle after WB.

## Structure
- Shared package ctrl_pkg holds:
  - the opcode constants;
  - the state enumeration (IDLE, FETCH0, FETCH1, EXEC, WB, HALT);
  - a onehot2to4 function;
  - the 18-bit strobe-vector bit indices.
- Sub-module op_decode is combinational: opcode → {strobe vector, is_alu, is_jump, hi_wb, is_hlt, is_illegal}.
- The top level holds the FSM, pc, instruction registers and output registers.

## Test plan
- Reset then release: all outputs at reset values. One cycle after release, mem_rd=1 and mem_addr=0x00.
- ADD R0,R3 (bytes 01, 30) with zero-wait memory:
  - cycle 3: IADD=1, EALU=1, Tgt1=0001, Tgt2=1000;
  - cycle 4: wb_en=1, flags_we=1, wb_hi_en=0;
  - next fetch at 0x02.
- MUL R1,R2 (05, 60): IMUL=1 with Tgt1=0010 and Tgt2=0100, then wb_en=wb_hi_en=flags_we=1.
- Jumps:
  - JA 0x40 with IJ=1 → next mem_addr=0x40.
  - JA 0x40 with IJ=0 → next mem_addr=pc+2.
  - JMP 0x80 with IJ=0 → 0x80.
  - No wb_en or flags_we in any jump case.
- mem_ack low for 3 cycles during FETCH1: mem_rd and mem_addr stay constant, with no strobe until ack.
- Termination and wrap:
  - Opcode 0x15 → halted=1, illegal=1, mem_rd stays 0.
  - HLT 0x1F → halted=1, illegal=0.
  - Instruction at 0xFF fetches its operand from 0x00, and pc ends at 0x01.
